pingpong_fmap_buffer: RTL and testbench

- Parametrised double-buffered (ping-pong) feature-map store for the int4 CNN datapath.
- A producer (input loader or previous layer) streams one frame of words into one bank.
- Meanwhile the consumer (conv window engine) randomly reads the other, completed bank.
- Banks swap ownership automatically, so a frame is loaded while the previous one is computed on.

---
 rtl/ppbuf_pkg.sv | 11 +
 rtl/ppbuf_bank_ram.sv | 40 ++++
 rtl/pingpong_fmap_buffer.sv | 147 ++++++++++++++
 tb/tb_pingpong_fmap_buffer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ppbuf_pkg.sv
// Shared constants and types for the ping-pong feature-map buffer.
package ppbuf_pkg;
  localparam int DEF_WIDTH     = 4;
  localparam int DEF_ADDR_BIT  = 10;
  localparam int DEF_DEPTH     = 1024;
  localparam int DEF_FRAME_LEN = 784;
  localparam int FRAME_CNT_W   = 16;

  // Bank index: selects one of the two ping-pong banks.
  typedef logic bank_t;
endpackage

// File: rtl/ppbuf_bank_ram.sv
// Simple dual-port bank RAM: port A writes, port B reads with a registered output.
// The output register holds its value when re is low, so the last read stays visible.
module ppbuf_bank_ram #(
  parameter int WIDTH         = 4,
  parameter int ADDR_BIT      = 10,
  parameter int DEPTH         = 1024,
  parameter     RAM_STYLE_VAL = "block"
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_BIT-1:0] waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                re,
  input  logic [ADDR_BIT-1:0] raddr,
  output logic [WIDTH-1:0]    rdata
);
  (* ram_style = RAM_STYLE_VAL *) logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] dout_d, dout_q;

  // Port A write; contents are never cleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Next read-data value: new word on a read, otherwise hold.
  always_comb begin
    dout_d = dout_q;
    if (re) dout_d = mem[raddr];
  end

  // Port B output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_q <= '0;
    else     dout_q <= dout_d;
  end

  assign rdata = dout_q;
endmodule

// File: rtl/pingpong_fmap_buffer.sv
// Double-buffered feature-map store: writer fills one bank while the reader
// randomly reads the other completed bank; banks swap ownership automatically.
// Optional macro PPBUF_RD_BOUNDS_EN adds read bounds checking and a sticky rd_err.
module pingpong_fmap_buffer
  import ppbuf_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int ADDR_BIT      = DEF_ADDR_BIT,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int FRAME_LEN     = DEF_FRAME_LEN,
  parameter     RAM_STYLE_VAL = "block"
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   rd_bank_ready,
  input  logic                   rd_en,
  input  logic [ADDR_BIT-1:0]    rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  input  logic                   rd_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`ifdef PPBUF_RD_BOUNDS_EN
  , output logic                 rd_err
`endif
);
  localparam logic [ADDR_BIT-1:0] LAST_ADDR = ADDR_BIT'(FRAME_LEN - 1);

  bank_t                   wr_bank_d, wr_bank_q;
  bank_t                   rd_bank_d, rd_bank_q;
  bank_t                   rd_sel_d,  rd_sel_q;
  logic [ADDR_BIT-1:0]     wr_addr_d, wr_addr_q;
  logic [1:0]              full_d, full_q;
  logic                    rd_valid_d, rd_valid_q;
  logic [FRAME_CNT_W-1:0]  frame_cnt_d, frame_cnt_q;
  logic                    wr_fire, rd_fire, rd_release;
  logic [1:0][WIDTH-1:0]   bank_rdata;

  // Handshake decode; a bank can never be both released and completed in one
  // cycle since the writer only owns empty banks and the reader only full ones.
  always_comb begin
    wr_ready      = !full_q[wr_bank_q];
    rd_bank_ready = full_q[rd_bank_q];
    wr_fire       = wr_valid && wr_ready;
    rd_fire       = rd_en && rd_bank_ready;
    rd_release    = rd_done && rd_bank_ready;
  end

  // Next-state for bank ownership, write pointer and read tracking.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_addr_d   = wr_addr_q;
    full_d      = full_q;
    frame_cnt_d = frame_cnt_q;
    if (wr_fire) begin
      if (wr_addr_q == LAST_ADDR) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_addr_d         = '0;
        frame_cnt_d       = frame_cnt_q + 1'b1;
      end else begin
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end
    if (rd_release) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
    // Output mux follows the bank that was actually read, so a release in the
    // same cycle still returns old-bank data and an ignored read holds rd_data.
    rd_valid_d = rd_fire;
    rd_sel_d   = rd_fire ? rd_bank_q : rd_sel_q;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_addr_q   <= '0;
      full_q      <= 2'b00;
      rd_valid_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      rd_sel_q    <= rd_sel_d;
      wr_addr_q   <= wr_addr_d;
      full_q      <= full_d;
      rd_valid_q  <= rd_valid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ppbuf_bank_ram #(
      .WIDTH        (WIDTH),
      .ADDR_BIT     (ADDR_BIT),
      .DEPTH        (DEPTH),
      .RAM_STYLE_VAL(RAM_STYLE_VAL)
    ) u_ram (
      .clk  (clk),
      .rst  (rst),
      .we   (wr_fire && (wr_bank_q == bank_t'(b))),
      .waddr(wr_addr_q),
      .wdata(wr_data),
      .re   (rd_fire && (rd_bank_q == bank_t'(b))),
      .raddr(rd_addr),
      .rdata(bank_rdata[b])
    );
  end

  assign rd_valid  = rd_valid_q;
  assign frame_cnt = frame_cnt_q;

`ifdef PPBUF_RD_BOUNDS_EN
  logic oob_d, oob_q, rd_err_d, rd_err_q;
  logic rd_oob;

  // Out-of-frame detection on an honoured read; the zeroing flag holds with rd_data.
  always_comb begin
    rd_oob   = 32'(rd_addr) >= FRAME_LEN;
    oob_d    = rd_fire ? rd_oob : oob_q;
    rd_err_d = rd_err_q || (rd_fire && rd_oob);
  end

  // Bounds flags: oob tracks the last honoured read, rd_err is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oob_q    <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      oob_q    <= oob_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign rd_err  = rd_err_q;
  assign rd_data = oob_q ? '0 : bank_rdata[rd_sel_q];
`else
  assign rd_data = bank_rdata[rd_sel_q];
`endif
endmodule

// File: tb/tb_pingpong_fmap_buffer.sv
// Directed self-checking bench for pingpong_fmap_buffer (default parameters).
module tb_pingpong_fmap_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid, wr_ready;
  logic [3:0]  wr_data;
  logic        rd_bank_ready, rd_en, rd_valid, rd_done;
  logic [9:0]  rd_addr;
  logic [3:0]  rd_data;
  logic [15:0] frame_cnt;
`ifdef PPBUF_RD_BOUNDS_EN
  logic        rd_err;
`endif

  int errs = 0;
  int checks = 0;

  pingpong_fmap_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_bank_ready(rd_bank_ready),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_done      (rd_done),
    .frame_cnt    (frame_cnt)
`ifdef PPBUF_RD_BOUNDS_EN
    , .rd_err     (rd_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push n words with data (start+i) truncated to 4 bits, one per cycle.
  task automatic wr_words(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = 4'(start + i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  // Push n words of a constant value.
  task automatic wr_const(input int n, input logic [3:0] val);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = val;
      tick();
    end
    wr_valid = 1'b0;
  endtask

  // One-cycle read, then check the registered result.
  task automatic rd_chk(input string tag, input int addr, input logic [3:0] exp);
    rd_en   = 1'b1;
    rd_addr = 10'(addr);
    tick();
    rd_en = 1'b0;
    chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
    chk({tag, "_dat"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
    #3;
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_rd_bank_ready", 32'(rd_bank_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`ifdef PPBUF_RD_BOUNDS_EN
    chk("rst_rd_err", 32'(rd_err), 32'd0);
`endif
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_rd_bank_ready", 32'(rd_bank_ready), 32'd0);

    // Frame 0 into bank 0: data = i[3:0].
    wr_words(783, 0);
    chk("f0_pre_last_ready", 32'(rd_bank_ready), 32'd0);
    chk("f0_pre_last_cnt", 32'(frame_cnt), 32'd0);
    wr_words(1, 783);
    chk("f0_ready", 32'(rd_bank_ready), 32'd1);
    chk("f0_cnt", 32'(frame_cnt), 32'd1);
    chk("f0_wr_ready", 32'(wr_ready), 32'd1);
    rd_chk("f0_rd0", 0, 4'h0);
    rd_chk("f0_rd5", 5, 4'h5);
    rd_chk("f0_rd783", 783, 4'hF);
    tick();
    chk("f0_rd_valid_drop", 32'(rd_valid), 32'd0);

    // Release bank 0; bank 1 empty so nothing is ready.
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("rel0_ready", 32'(rd_bank_ready), 32'd0);
    // Read while nothing ready: ignored, rd_data holds last value.
    rd_en = 1'b1; rd_addr = 10'd5; tick(); rd_en = 1'b0;
    chk("ign_rd_valid", 32'(rd_valid), 32'd0);
    chk("ign_rd_data", 32'(rd_data), 32'hF);
    // rd_done while nothing ready: ignored.
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("ign_done_ready", 32'(rd_bank_ready), 32'd0);

    // Two frames without release: A into bank 1, 5 into bank 0.
    wr_const(784, 4'hA);
    chk("fA_ready", 32'(rd_bank_ready), 32'd1);
    chk("fA_wr_ready", 32'(wr_ready), 32'd1);
    wr_const(784, 4'h5);
    chk("f5_wr_ready", 32'(wr_ready), 32'd0);
    chk("f5_cnt", 32'(frame_cnt), 32'd3);
    // Stalled producer: nothing may be accepted.
    wr_const(5, 4'h9);
    chk("stall_wr_ready", 32'(wr_ready), 32'd0);
    chk("stall_cnt", 32'(frame_cnt), 32'd3);
    rd_chk("fA_rd3", 3, 4'hA);
    // Read and release in the same cycle: old bank data comes back.
    rd_en = 1'b1; rd_done = 1'b1; rd_addr = 10'd10;
    tick();
    rd_en = 1'b0; rd_done = 1'b0;
    chk("same_rd_valid", 32'(rd_valid), 32'd1);
    chk("same_rd_data", 32'(rd_data), 32'hA);
    chk("same_ready", 32'(rd_bank_ready), 32'd1);
    chk("same_wr_ready", 32'(wr_ready), 32'd1);
    rd_chk("f5_rd100", 100, 4'h5);
    // Writer refills released bank 1; bank 0 flag untouched.
    wr_const(3, 4'h1);
    chk("refill_ready", 32'(rd_bank_ready), 32'd1);
    rd_chk("f5_rd700", 700, 4'h5);

    // Reset after 400 words of a fresh fill.
    wr_const(397, 4'h3);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(rd_bank_ready), 32'd0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    wr_words(783, 3);
    chk("post_rst_pre_last", 32'(rd_bank_ready), 32'd0);
    wr_words(1, 786);
    chk("post_rst_ready", 32'(rd_bank_ready), 32'd1);
    chk("post_rst_cnt", 32'(frame_cnt), 32'd1);
    chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    rd_chk("post_rst_rd0", 0, 4'h3);
    rd_chk("post_rst_rd783", 783, 4'h2);

`ifdef PPBUF_RD_BOUNDS_EN
    rd_chk("oob_rd800", 800, 4'h0);
    chk("oob_err", 32'(rd_err), 32'd1);
    rd_chk("oob_then_rd1", 1, 4'h4);
    chk("oob_err_sticky", 32'(rd_err), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    chk("oob_err_cleared", 32'(rd_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
